// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the data SRAM response model: size encodings,
// default geometry and the byte-lane merge helper.
package data_sram_resp_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DEPTH    = 2;
    localparam int DEF_RESP_LAT = 2;
    localparam int TIMER_W      = 4;

    // Replace only the byte lanes whose strobe is set; other lanes keep old data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// SRAM-style request/response bus between an initiator and the response model.
interface data_sram_resp_if;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        stall_addr;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata, stall_addr,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata, stall_addr,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

endinterface

// File: rtl/data_sram_resp_resp_queue.sv
// Circular buffer of accepted requests; each entry carries a latency timer and
// the head entry retires in the first cycle its timer reads zero.
module resp_queue
    import data_sram_resp_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RESP_LAT = DEF_RESP_LAT,
    parameter int IDX_W    = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_s,
    input  logic             push_wr_s,
    input  logic [IDX_W-1:0] push_idx_s,
    input  logic [3:0]       push_wstrb_s,
    input  logic [31:0]      push_wdata_s,
    output logic             not_full_s,
    output logic             pop_s,
    output logic             head_wr_s,
    output logic [IDX_W-1:0] head_idx_s,
    output logic [3:0]       head_wstrb_s,
    output logic [31:0]      head_wdata_s
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(RESP_LAT - 1);

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [TIMER_W-1:0] timer_q [DEPTH];
    logic [TIMER_W-1:0] timer_d [DEPTH];
    logic               wr_q    [DEPTH];
    logic               wr_d    [DEPTH];
    logic [IDX_W-1:0]   idx_q   [DEPTH];
    logic [IDX_W-1:0]   idx_d   [DEPTH];
    logic [3:0]         strb_q  [DEPTH];
    logic [3:0]         strb_d  [DEPTH];
    logic [31:0]        wdata_q [DEPTH];
    logic [31:0]        wdata_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok_s;

    // Advance a pointer, wrapping at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Head status and payload as seen by the memory side.
    always_comb begin
        not_full_s   = (count_q < CNT_W'(DEPTH));
        push_ok_s    = push_s & not_full_s;
        pop_s        = valid_q[head_q] & (timer_q[head_q] == '0);
        head_wr_s    = wr_q[head_q];
        head_idx_s   = idx_q[head_q];
        head_wstrb_s = strb_q[head_q];
        head_wdata_s = wdata_q[head_q];
    end

    // Next-state: age timers, retire the head, append the new request.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            wr_d[i]    = wr_q[i];
            idx_d[i]   = idx_q[i];
            strb_d[i]  = strb_q[i];
            wdata_d[i] = wdata_q[i];
            if (valid_q[i] && (timer_q[i] != '0)) begin
                timer_d[i] = timer_q[i] - TIMER_W'(1);
            end else begin
                timer_d[i] = timer_q[i];
            end
        end
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            head_d          = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (push_ok_s) begin
            valid_d[tail_q] = 1'b1;
            timer_d[tail_q] = TIMER_LOAD;
            wr_d[tail_q]    = push_wr_s;
            idx_d[tail_q]   = push_idx_s;
            strb_d[tail_q]  = push_wstrb_s;
            wdata_d[tail_q] = push_wdata_s;
            tail_d          = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset discards every pending entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                timer_q[i] <= '0;
                wr_q[i]    <= 1'b0;
                idx_q[i]   <= '0;
                strb_q[i]  <= 4'h0;
                wdata_q[i] <= 32'h0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                timer_q[i] <= timer_d[i];
                wr_q[i]    <= wr_d[i];
                idx_q[i]   <= idx_d[i];
                strb_q[i]  <= strb_d[i];
                wdata_q[i] <= wdata_d[i];
            end
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM response model: accepts requests into a latency queue and answers
// them in order from an internal word memory with byte-lane write merging.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RESP_LAT = DEF_RESP_LAT
) (
    input  logic               clk,
    input  logic               resetn,
    data_sram_resp_if.slave    bus
);

    localparam int WORDS = 1 << ADDR_W;

    logic [31:0]       mem_q [WORDS];
    logic              not_full_s;
    logic              accept_s;
    logic              pop_s;
    logic              head_wr_s;
    logic [ADDR_W-1:0] head_idx_s;
    logic [3:0]        head_wstrb_s;
    logic [31:0]       head_wdata_s;
    logic [31:0]       mem_wdata_d;
    logic              mem_we_s;
    logic [31:0]       rdata_s;
    logic              unused_s;

    // Size and the non-index address bits carry no meaning for this model.
    assign unused_s = ^{bus.data_sram_size, bus.data_sram_addr[31:ADDR_W+2],
                        bus.data_sram_addr[1:0]};

    // Acceptance uses the pre-retire occupancy, so a full queue never bypasses.
    always_comb begin
        accept_s = bus.data_sram_req & ~bus.stall_addr & not_full_s;
    end

    resp_queue #(
        .DEPTH    (DEPTH),
        .RESP_LAT (RESP_LAT),
        .IDX_W    (ADDR_W)
    ) u_resp_queue (
        .clk          (clk),
        .resetn       (resetn),
        .push_s       (accept_s),
        .push_wr_s    (bus.data_sram_wr),
        .push_idx_s   (bus.data_sram_addr[ADDR_W+1:2]),
        .push_wstrb_s (bus.data_sram_wstrb),
        .push_wdata_s (bus.data_sram_wdata),
        .not_full_s   (not_full_s),
        .pop_s        (pop_s),
        .head_wr_s    (head_wr_s),
        .head_idx_s   (head_idx_s),
        .head_wstrb_s (head_wstrb_s),
        .head_wdata_s (head_wdata_s)
    );

    // Retire-side datapath: merged write word and read data for the head entry.
    always_comb begin
        mem_we_s    = pop_s & head_wr_s;
        mem_wdata_d = merge_bytes(mem_q[head_idx_s], head_wdata_s, head_wstrb_s);
        if (pop_s && !head_wr_s) begin
            rdata_s = mem_q[head_idx_s];
        end else begin
            rdata_s = 32'h0;
        end
    end

    // Backing memory is deliberately left unreset so preloaded contents survive.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[head_idx_s] <= mem_wdata_d;
        end
    end

    assign bus.data_sram_addr_ok = accept_s;
    assign bus.data_sram_data_ok = pop_s;
    assign bus.data_sram_rdata   = rdata_s;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: a table of isolated transactions followed
// by hand-written multi-cycle sequences for queueing, stall and reset cases.
module tb_data_sram_resp;

    logic clk;
    logic resetn;
    int   n_chk;
    int   n_err;

    data_sram_resp_if bus ();

    data_sram_resp dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic wr, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] wdata);
        bus.data_sram_req   = req;
        bus.data_sram_wr    = wr;
        bus.data_sram_size  = 2'd2;
        bus.data_sram_addr  = addr;
        bus.data_sram_wstrb = strb;
        bus.data_sram_wdata = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        resetn = 1'b0;
        bus.stall_addr = 1'b0;
        idle();

        vecs[0]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,         32'h1122_3344};
        vecs[1]  = '{1'b1, 32'h0000_0044, 4'h6, 32'hAABB_CCDD, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0044, 4'h0, 32'h0,         32'h00BB_CC00};
        vecs[3]  = '{1'b1, 32'h0000_0048, 4'h0, 32'hFFFF_FFFF, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0048, 4'h0, 32'h0,         32'hCAFE_BABE};
        vecs[5]  = '{1'b1, 32'h0000_004C, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_004C, 4'h0, 32'h0,         32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 32'h0000_004C, 4'h1, 32'h0000_00AA, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_004C, 4'h0, 32'h0,         32'hDEAD_BEAA};
        vecs[9]  = '{1'b1, 32'h0000_004C, 4'h8, 32'h1100_0000, 32'h0};
        vecs[10] = '{1'b0, 32'hFFFF_F04E, 4'h0, 32'h0,         32'h11AD_BEAA};

        dut.mem_q[16] = 32'h1122_3344;
        dut.mem_q[17] = 32'h0000_0000;
        dut.mem_q[18] = 32'hCAFE_BABE;
        dut.mem_q[19] = 32'h0000_0000;
        dut.mem_q[32] = 32'h0000_0000;
        dut.mem_q[33] = 32'h0101_0101;
        dut.mem_q[34] = 32'h0202_0202;

        // Reset state
        @(negedge clk);
        check("rst_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        check("rst_rdata", bus.data_sram_rdata, 32'h0);
        check("rst_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h0);
        next_cyc();
        resetn = 1'b1;
        next_cyc();

        // Isolated transactions: accept at T, data_ok exactly at T+2
        for (int v = 0; v < 11; v++) begin
            drive(1'b1, vecs[v].wr, vecs[v].addr, vecs[v].wstrb, vecs[v].wdata);
            @(negedge clk);
            check($sformatf("v%0d_addr_ok", v), {31'h0, bus.data_sram_addr_ok}, 32'h1);
            check($sformatf("v%0d_early_ok", v), {31'h0, bus.data_sram_data_ok}, 32'h0);
            next_cyc();
            idle();
            @(negedge clk);
            check($sformatf("v%0d_t1_ok", v), {31'h0, bus.data_sram_data_ok}, 32'h0);
            next_cyc();
            @(negedge clk);
            check($sformatf("v%0d_data_ok", v), {31'h0, bus.data_sram_data_ok}, 32'h1);
            check($sformatf("v%0d_rdata", v), bus.data_sram_rdata, vecs[v].exp_rdata);
            next_cyc();
            @(negedge clk);
            check($sformatf("v%0d_after_ok", v), {31'h0, bus.data_sram_data_ok}, 32'h0);
            next_cyc();
        end

        // Three back-to-back reads against a two-entry queue
        drive(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        @(negedge clk);
        check("bb_a_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
        @(negedge clk);
        check("bb_b_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        check("bb_c1_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h48, 4'h0, 32'h0);
        @(negedge clk);
        check("bb_c_full", {31'h0, bus.data_sram_addr_ok}, 32'h0);
        check("bb_a_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h1);
        check("bb_a_rdata", bus.data_sram_rdata, 32'h1122_3344);
        next_cyc();
        @(negedge clk);
        check("bb_c_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        check("bb_b_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h1);
        check("bb_b_rdata", bus.data_sram_rdata, 32'h00BB_CC00);
        next_cyc();
        idle();
        @(negedge clk);
        check("bb_gap_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        next_cyc();
        @(negedge clk);
        check("bb_c_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h1);
        check("bb_c_rdata", bus.data_sram_rdata, 32'hCAFE_BABE);
        next_cyc();
        @(negedge clk);
        check("bb_end_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        next_cyc();

        // Write immediately followed by read of the same word
        drive(1'b1, 1'b1, 32'h80, 4'hF, 32'h1234_5678);
        @(negedge clk);
        check("wr_rd_w_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b0, 32'h80, 4'h0, 32'h0);
        @(negedge clk);
        check("wr_rd_r_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        next_cyc();
        idle();
        @(negedge clk);
        check("wr_rd_w_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h1);
        check("wr_rd_w_rdata", bus.data_sram_rdata, 32'h0);
        next_cyc();
        @(negedge clk);
        check("wr_rd_r_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h1);
        check("wr_rd_r_rdata", bus.data_sram_rdata, 32'h1234_5678);
        next_cyc();

        // Stall held for five cycles, then released
        bus.stall_addr = 1'b1;
        drive(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_addr_ok", c), {31'h0, bus.data_sram_addr_ok}, 32'h0);
            check($sformatf("stall%0d_data_ok", c), {31'h0, bus.data_sram_data_ok}, 32'h0);
            next_cyc();
        end
        bus.stall_addr = 1'b0;
        @(negedge clk);
        check("unstall_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        next_cyc();
        idle();
        @(negedge clk);
        check("unstall_t1_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        next_cyc();
        @(negedge clk);
        check("unstall_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h1);
        check("unstall_rdata", bus.data_sram_rdata, 32'h1122_3344);
        next_cyc();

        // Reset pulse with two writes pending
        drive(1'b1, 1'b1, 32'h84, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        check("rp_w0_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b1, 32'h88, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk);
        check("rp_w1_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        next_cyc();
        idle();
        resetn = 1'b0;
        @(negedge clk);
        check("rp_rst_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        check("rp_rst_rdata", bus.data_sram_rdata, 32'h0);
        next_cyc();
        resetn = 1'b1;
        @(negedge clk);
        check("rp_rel_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h84, 4'h0, 32'h0);
        @(negedge clk);
        check("rp_r0_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        check("rp_r0_idle_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h88, 4'h0, 32'h0);
        @(negedge clk);
        check("rp_r1_addr_ok", {31'h0, bus.data_sram_addr_ok}, 32'h1);
        check("rp_r1_idle_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);
        next_cyc();
        idle();
        @(negedge clk);
        check("rp_r0_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h1);
        check("rp_r0_rdata", bus.data_sram_rdata, 32'h0101_0101);
        next_cyc();
        @(negedge clk);
        check("rp_r1_data_ok", {31'h0, bus.data_sram_data_ok}, 32'h1);
        check("rp_r1_rdata", bus.data_sram_rdata, 32'h0202_0202);
        next_cyc();
        @(negedge clk);
        check("rp_end_ok", {31'h0, bus.data_sram_data_ok}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the internal backing memory (1024 words).
REQ-002 Parameter DEPTH, default 2, number of outstanding accepted-but-unanswered requests.
REQ-003 Parameter RESP_LAT, default 2, minimum cycles from address acceptance to data_ok; legal range 1..15.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 data_sram_req  in  1  initiator request valid.
REQ-007 data_sram_wr  in  1  1 = write, 0 = read.
REQ-008 data_sram_size  in  2  0 byte, 1 half, 2 word; informational, not used for write masking.
REQ-009 data_sram_wstrb  in  4  byte-lane write enables.
REQ-010 data_sram_addr  in  32  byte address; bits [ADDR_W+1:2] index the memory, all other bits ignored.
REQ-011 data_sram_wdata  in  32  write data, lane-aligned by the initiator.
REQ-012 stall_addr  in  1  bench back-pressure; forces data_sram_addr_ok low.
REQ-013 data_sram_addr_ok  out  1  request accepted this cycle.
REQ-014 data_sram_data_ok  out  1  one response (read data or write completion) this cycle.
REQ-015 data_sram_rdata  out  32  read data, valid only when data_ok is high for a read.

Function
REQ-016 data_sram_addr_ok SHALL equal data_sram_req & ~stall_addr & (count < DEPTH); it is combinational.
REQ-017 A request SHALL be accepted when req & addr_ok; wr, word index, wstrb, and wdata SHALL be captured into a circular queue of DEPTH entries, and the entry's timer SHALL be loaded with RESP_LAT-1.
REQ-018 Every valid entry's timer SHALL decrement by 1 per cycle, saturating at 0.
REQ-019 The head entry SHALL retire in the first cycle its timer reads 0, asserting data_ok high for exactly that cycle; responses SHALL be strictly in acceptance order, at most one per cycle.
REQ-020 Accepted in cycle T with an empty queue: data_ok SHALL occur in cycle T+RESP_LAT; a queued entry SHALL respond no earlier than one cycle after its predecessor.
REQ-021 On a write retire, memory bytes SHALL be updated only on lanes where the captured wstrb is 1; wstrb = 0 SHALL complete with data_ok and leave memory unchanged.
REQ-022 On a read retire, rdata SHALL present the full memory word at the captured index in the same cycle, including all writes retired in earlier cycles; otherwise rdata SHALL be 0.
REQ-023 Accept and retire in the same cycle SHALL both take effect; count SHALL remain unchanged; addr_ok SHALL use the pre-retire count (no full-queue bypass).
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH and never over- or underflow.
REQ-025 data_ok SHALL never assert with an empty queue; addr_ok SHALL assert only when req is high.

Reset
REQ-026 While resetn is low, count, head, tail, timers, and entry-valid bits SHALL clear asynchronously; data_ok SHALL be 0 and rdata SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending entries, produce no later data_ok for them, and write nothing to memory.
REQ-028 Memory contents SHALL NOT be reset; the bench preloads them through hierarchical access.

Structure
REQ-029 The shared header SHALL hold the size encodings (BYTE = 0, HALF = 1, WORD = 2) and the default values of RESP_LAT and DEPTH.
REQ-030 One sub-module, resp_queue, SHALL implement the DEPTH-entry circular buffer with per-entry timers; the memory array and byte merge SHALL stay in data_sram_resp.

Verification
REQ-031 Preload word 0x10 = 0x11223344; read addr 0x40 accepted at T -> data_ok at T+2 with rdata 0x11223344.
REQ-032 Write addr 0x44, wstrb 4'b0110, wdata 0xAABBCCDD over old 0x00000000, then read 0x44 -> rdata 0x00BBCC00.
REQ-033 Three back-to-back reqs with DEPTH = 2 -> addr_ok high for the first two, low for the third until the first retires, then the third is accepted; data_ok appears in order.
REQ-034 Write 0x12345678 to 0x80 immediately followed by a read of 0x80 -> data_ok on consecutive cycles; the read returns 0x12345678.
REQ-035 Hold stall_addr = 1 for 5 cycles with req = 1 -> addr_ok stays 0 and no data_ok occurs; release -> acceptance in the same cycle.
REQ-036 Two requests queued, then resetn pulsed low for 1 cycle -> no data_ok occurs afterwards, memory is unchanged, and addr_ok resumes the cycle after release.
